// File: rtl/song_sequencer_if.sv
// Bundles the sequencer's control, ROM and tone-generator signals.
interface song_sequencer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [2:0]        mode;
    logic              pause;
    logic [1:0]        song_num;
    logic [ADDR_W+1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [4:0]        note;
    logic              playing;
    logic              song_done;

    // Sequencer side.
    modport master (
        input  mode, pause, song_num, rom_data,
        output rom_addr, note, playing, song_done
    );

    // Controller / ROM / tone-generator side.
    modport slave (
        output mode, pause, song_num, rom_data,
        input  rom_addr, note, playing, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song in ROM, timing each note in beats and inserting
// a silent gap after every note. Handles pause, song change and end of song.
module song_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    song_sequencer_if.master bus
);

    localparam logic [2:0]  MODE_PLAY = 3'b011;
    localparam logic [4:0]  CODE_END  = 5'h1F;
    localparam int unsigned MAX_CYC   = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          song_reg_q, song_reg_d;
    logic [2:0]          beat_q, beat_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [4:0]          cur_note_q, cur_note_d;
    logic [4:0]          note_q, note_d;
    logic                playing_q, playing_d;
    logic                song_done_q, song_done_d;
    logic [ADDR_W+1:0]   rom_addr_q, rom_addr_d;

    logic [4:0] rom_code;
    logic [2:0] rom_dur;

    assign rom_code = bus.rom_data[7:3];
    assign rom_dur  = bus.rom_data[2:0];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            song_reg_q  <= '0;
            beat_q      <= '0;
            cyc_q       <= '0;
            cur_note_q  <= '0;
            note_q      <= '0;
            playing_q   <= 1'b0;
            song_done_q <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            song_reg_q  <= song_reg_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            cur_note_q  <= cur_note_d;
            note_q      <= note_d;
            playing_q   <= playing_d;
            song_done_q <= song_done_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    // Next-state logic: mode exit > song change > pause > normal flow.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        song_reg_d = song_reg_q;
        beat_d     = beat_q;
        cyc_d      = cyc_q;
        cur_note_d = cur_note_q;

        if (bus.mode != MODE_PLAY) begin
            state_d    = S_IDLE;
            idx_d      = '0;
            beat_d     = '0;
            cyc_d      = '0;
            cur_note_d = '0;
        end else if ((state_q != S_IDLE) && (bus.song_num != song_reg_q)) begin
            state_d    = S_FETCH;
            idx_d      = '0;
            song_reg_d = bus.song_num;
            beat_d     = '0;
            cyc_d      = '0;
            cur_note_d = '0;
        end else if (bus.pause && (state_q != S_DONE)) begin
            // Freeze everything; outputs are silenced below.
            state_d = state_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d    = S_FETCH;
                    song_reg_d = bus.song_num;
                    idx_d      = '0;
                    beat_d     = '0;
                    cyc_d      = '0;
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (rom_code == CODE_END) begin
                        state_d    = S_DONE;
                        cur_note_d = '0;
                    end else begin
                        state_d    = S_PLAY;
                        cur_note_d = rom_code;
                        beat_d     = rom_dur;
                        cyc_d      = '0;
                    end
                end
                S_PLAY: begin
                    if (cyc_q == BEAT_LAST) begin
                        cyc_d = '0;
                        if (beat_q != 3'd0) begin
                            beat_d = beat_q - 3'd1;
                        end else begin
                            state_d    = S_GAP;
                            cur_note_d = '0;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cyc_q == GAP_LAST) begin
                        cyc_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output values registered alongside the state they describe.
    always_comb begin
        note_d      = '0;
        playing_d   = 1'b0;
        song_done_d = 1'b0;
        rom_addr_d  = '0;
        if ((state_d == S_PLAY) && !bus.pause) begin
            note_d    = cur_note_d;
            playing_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            song_done_d = 1'b1;
        end
        if (state_d != S_IDLE) begin
            rom_addr_d = {song_reg_d, idx_d};
        end
    end

    assign bus.note      = note_q;
    assign bus.playing   = playing_q;
    assign bus.song_done = song_done_q;
    assign bus.rom_addr  = rom_addr_q;

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Plays stored songs note by note in play mode (`mode == 3'b011`), using the `song_num` and `pause` outputs of the play-mode button controller. Each cycle it addresses the song ROM and times every note with a beat counter. It drives the note code to the tone generator and handles pause, song change and end of song.

## Interface
- `BEAT_CYCLES`, default 12_500_000: clock cycles per beat.
- `GAP_CYCLES`, default 1_250_000: silent cycles inserted after every note.
- `ADDR_W`, default 6: per-song index width, giving 64 entries per song.
- `clk`  in  1: system clock. All logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `mode`  in  3: global mode. The block is active only when `mode == 3'b011`.
- `pause`  in  1: pause level from the controller.
- `song_num`  in  2: song select from the controller.
- `rom_addr`  out  2+ADDR_W: `{song_num, idx}`.
- `rom_data`  in  8: registered ROM output, valid 1 cycle after `rom_addr`.
  - `[7:3]` note code: 0 = rest, 1–21 = notes, 5'h1F = end marker.
  - `[2:0]` duration in beats minus 1.
- `note`  out  5: current note code to the tone generator. 0 = silent.
- `playing`  out  1: high in PLAY while not paused.
- `song_done`  out  1: high in DONE.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- Internal registers:
  - `idx` (ADDR_W bits).
  - `song_reg` (2 bits).
  - beat counter (3 bits).
  - cycle counter, wide enough for max(BEAT_CYCLES, GAP_CYCLES).
- Priority, highest first: `rst` > mode exit > song change > `pause` > normal flow.
- `rst` sets:
  - state IDLE.
  - `idx`, `song_reg` and all counters to 0.
  - `note`, `playing`, `song_done` and `rom_addr` to 0.
- Mode exit: if `mode != 3'b011`, go to IDLE next cycle with `idx` = 0 and all outputs 0, from any state.
- IDLE → FETCH when `mode == 3'b011` and `!pause`. On this transition `song_reg <= song_num` and `idx <= 0`.
- FETCH: drive `rom_addr = {song_reg, idx}`, then go to LOAD.
- LOAD: sample `rom_data`.
  - Code is 5'h1F: go to DONE.
  - Otherwise: go to PLAY. Load `note` = code, beat counter = duration, cycle counter = 0.
  - Code 0 is a timed rest: `note` = 0 but the state is still PLAY.
- PLAY: the cycle counter counts 0..BEAT_CYCLES-1.
  - At wrap with beat counter > 0: decrement the beat counter.
  - At wrap with beat counter = 0: go to GAP, `note` = 0, cycle counter = 0.
- GAP: count 0..GAP_CYCLES-1. At the end:
  - If `idx` = 2^ADDR_W-1 (last entry): go to DONE (index wrap is end of song).
  - Otherwise: `idx` = `idx`+1 and go to FETCH.
- DONE: `note` = 0 and `song_done` = 1. Hold here until mode exit or a song change.
- Song change: if `song_num != song_reg` in any state other than IDLE:
  - Next cycle go to FETCH with `idx` = 0 and `song_reg` = `song_num`.
  - `note` = 0 and `song_done` = 0. All counters are cleared.
  - This takes precedence over `pause`.
- Pause: while `pause` = 1 in FETCH, LOAD, PLAY or GAP:
  - State and all counters hold. `note` is forced to 0 and `playing` = 0.
  - Deasserting `pause` resumes on the next cycle with the remaining duration intact and `note` restored.
  - `pause` has no effect in DONE.
  - While in IDLE, `pause` = 1 keeps the block in IDLE.
- `rom_data` is ignored outside LOAD.

## Timing
- Start latency: `mode` and `!pause` seen in IDLE at cycle 0.
  - FETCH at cycle 1, LOAD at cycle 2.
  - `note` valid from cycle 3.
- Sounding length per note: (dur+1)·BEAT_CYCLES cycles.
- Note-to-note period: (dur+1)·BEAT_CYCLES + GAP_CYCLES + 2 cycles.
- Song-change response: `note` = 0 on the next cycle. The new song's first note is valid 3 cycles after the change is sampled.
- Mode-exit response: all outputs 0 on the next cycle.
- All outputs are registered. No combinational path runs from any input to any output.

## Test plan
- Parameters for all scenarios: BEAT_CYCLES = 4, GAP_CYCLES = 2, ADDR_W = 2.
- Basic play: song 0 = {note 5 dur 1, note 9 dur 0, 5'h1F}, mode = 3 →
  - `note` = 5 for 8 cycles starting at cycle 3.
  - 0 for 4 cycles.
  - `note` = 9 for 4 cycles.
  - `song_done` = 1 four cycles after the second note ends (2 GAP + FETCH + LOAD).
- Pause: `pause` raised for 10 cycles after 3 cycles of note 5 (dur 1) →
  - `note` = 0 and `playing` = 0 for those 10 cycles.
  - Then 5 more cycles of note 5.
- Song change: `song_num` changes 0→1 during PLAY →
  - `note` = 0 the next cycle.
  - `rom_addr` = {2'd1, 2'd0} in FETCH.
  - Song 1's first note 3 cycles after the change is sampled.
- Index wrap: song with 4 notes and no end marker → DONE after the 4th note's GAP, with no fetch of `idx` 0.
- Mode exit and reset:
  - `mode` = 3'b001 mid-note → next cycle IDLE, all outputs 0.
  - `rst` during GAP → every output 0 on the next cycle. No restart until `rst` is low and the IDLE start condition holds.
